// File: rtl/apb_uart_tx_model.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_tx_model
// Purpose  : APB 16550-style UART transmitter: TX FIFO + cycle-timed 8N1 line.
//            Define UART_PRINT_EN to echo each popped byte to the console.
// Revision : 1.0
// ============================================================================
module apb_uart_tx_model #(
   parameter int unsigned TX_DEPTH   = 16,
   parameter int unsigned ADDR_SHIFT = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic        pwrite_i,
   input  logic [31:0] paddr_i,
   input  logic [31:0] pwdata_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int unsigned C_PTR_W = $clog2(TX_DEPTH);
   localparam int unsigned C_CNT_W = C_PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [3:0]         r_ier;
   logic [7:0]         r_lcr;
   logic [4:0]         r_mcr;
   logic [7:0]         r_lsr;
   logic [7:0]         r_msr;
   logic [7:0]         r_scr;
   logic [7:0]         r_dll;
   logic [7:0]         r_dlm;
   logic               r_fifo_en;

   logic [7:0]         r_mem [TX_DEPTH];
   logic [C_PTR_W-1:0] r_wptr;
   logic [C_PTR_W-1:0] r_rptr;
   logic [C_CNT_W-1:0] r_count;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [15:0]        r_baud;
   logic [15:0]        w_baud_nxt;
   logic [2:0]         r_bit;
   logic [2:0]         w_bit_nxt;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_nxt;
   logic               r_tx;
   logic               w_tx_nxt;
   logic               w_pop;

   logic [2:0]         w_idx;
   logic               w_wr;
   logic               w_rd;
   logic               w_thr_wr;
   logic               w_push;
   logic               w_flush;
   logic               w_empty;
   logic               w_full;
   logic               w_thre;
   logic               w_temt;
   logic [15:0]        w_div;
   logic [7:0]         w_rdata;
   logic               w_unused;

   assign w_idx    = paddr_i[ADDR_SHIFT +: 3];
   assign w_wr     = psel_i & penable_i & pwrite_i;
   assign w_rd     = psel_i & penable_i & ~pwrite_i;
   assign w_thr_wr = w_wr && (w_idx == 3'd0) && !r_lcr[7];
   assign w_flush  = w_wr && (w_idx == 3'd2) && pwdata_i[2];
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == C_CNT_W'(TX_DEPTH));
   // A pop from a full FIFO frees the slot the stalled write lands in this cycle.
   assign w_push   = w_thr_wr && (!w_full || w_pop);
   assign w_thre   = w_empty;
   assign w_temt   = w_empty && (r_state == S_IDLE);
   assign w_div    = ({r_dlm, r_dll} == 16'd0) ? 16'd1 : {r_dlm, r_dll};

   assign pready_o  = !(w_thr_wr && w_full && !w_pop);
   assign pslverr_o = 1'b0;
   assign tx_o      = r_tx;
   assign irq_o     = r_ier[1] && w_thre;
   assign prdata_o  = w_rd ? {24'd0, w_rdata} : 32'd0;
   assign w_unused  = ^{paddr_i, pwdata_i[31:8], r_lsr[6:5], r_lsr[0]};

   always_comb begin
      w_rdata = 8'd0;
      case (w_idx)
         3'd0: w_rdata = r_lcr[7] ? r_dll : 8'd0;
         3'd1: w_rdata = r_lcr[7] ? r_dlm : {4'd0, r_ier};
         3'd2: w_rdata = {(r_fifo_en ? 2'b11 : 2'b00), 2'b00, (irq_o ? 4'h2 : 4'h1)};
         3'd3: w_rdata = r_lcr;
         3'd4: w_rdata = {3'd0, r_mcr};
         3'd5: w_rdata = {r_lsr[7], w_temt, w_thre, r_lsr[4:1], 1'b0};
         3'd6: w_rdata = r_msr;
         3'd7: w_rdata = r_scr;
         default: w_rdata = 8'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ier     <= '0;
         r_lcr     <= '0;
         r_mcr     <= '0;
         r_lsr     <= '0;
         r_msr     <= '0;
         r_scr     <= '0;
         r_dll     <= '0;
         r_dlm     <= '0;
         r_fifo_en <= 1'b0;
      end else if (w_wr) begin
         case (w_idx)
            3'd0: if (r_lcr[7]) r_dll <= pwdata_i[7:0];
            3'd1: if (r_lcr[7]) r_dlm <= pwdata_i[7:0];
                  else          r_ier <= pwdata_i[3:0];
            3'd2: r_fifo_en <= pwdata_i[0];
            3'd3: r_lcr <= pwdata_i[7:0];
            3'd4: r_mcr <= pwdata_i[4:0];
            3'd5: r_lsr <= pwdata_i[7:0];
            3'd6: r_msr <= pwdata_i[7:0];
            3'd7: r_scr <= pwdata_i[7:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= pwdata_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   // Every bit boundary reloads the baud counter from the live divisor.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
               w_tx_nxt    = 1'b0;
               w_baud_nxt  = w_div - 16'd1;
               w_shift_nxt = r_mem[r_rptr];
            end
         end
         S_START: begin
            if (r_baud == 16'd0) begin
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
               w_bit_nxt   = 3'd0;
               w_baud_nxt  = w_div - 16'd1;
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         S_DATA: begin
            if (r_baud == 16'd0) begin
               w_baud_nxt = w_div - 16'd1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = r_shift >> 1;
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         S_STOP: begin
            if (r_baud == 16'd0) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
                  w_tx_nxt    = 1'b0;
                  w_baud_nxt  = w_div - 16'd1;
                  w_shift_nxt = r_mem[r_rptr];
               end else begin
                  w_state_nxt = S_IDLE;
                  w_tx_nxt    = 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

`ifdef UART_PRINT_EN
   always_ff @(posedge clk_i) begin
      if (w_pop) begin
         if (r_mem[r_rptr] == 8'h0A)      $write("\n");
         else if (r_mem[r_rptr] != 8'h0D) $write("%c", r_mem[r_rptr]);
      end
   end
`endif

endmodule
`default_nettype wire
